fetch_unit_q: RTL and testbench

- Parametrised, queued instruction fetch unit; successor to the single-register IF stage.
- Issues word fetches to instruction memory over a valid/ready request channel and buffers returned words in a FIFO_DEPTH instruction queue.
- Resolves unconditional and conditional branches at the queue head against the CPSR flags.
- Delivers non-branch instructions with their PC to decode over a valid/ready handshake.

---
 rtl/fetch_pkg.sv | 35 +++
 rtl/cond_eval.sv | 39 +++
 rtl/fetch_unit_q.sv | 152 +++++++++++++++
 tb/tb_fetch_unit_q.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared encodings for the queued fetch unit: branch class, condition codes,
// CPSR flag bit positions and the fetch FSM state type.
package fetch_pkg;

   localparam logic [2:0] BR_CLASS = 3'b110;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int FLAG_N = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT
   } fetch_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch condition evaluator over CPSR {N,C,Z,V}.
module cond_eval
   import fetch_pkg::*;
(
   input  logic [3:0] flags,
   input  logic [3:0] cond,
   output logic       taken
);

   logic n, c, z, v;

   assign n = flags[FLAG_N];
   assign c = flags[FLAG_C];
   assign z = flags[FLAG_Z];
   assign v = flags[FLAG_V];

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_EQ: taken = z;
         COND_NE: taken = !z;
         COND_CS: taken = c;
         COND_CC: taken = !c;
         COND_MI: taken = n;
         COND_PL: taken = !n;
         COND_VS: taken = v;
         COND_VC: taken = !v;
         COND_HI: taken = c && !z;
         COND_LS: taken = !(c && !z);
         COND_GE: taken = (n == v);
         COND_LT: taken = (n != v);
         COND_GT: taken = !z && (n == v);
         COND_LE: taken = !(!z && (n == v));
         COND_AL: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/fetch_unit_q.sv
// Queued instruction fetch: one outstanding imem request, FIFO of {instr, pc},
// branches resolved at the queue head, non-branches handed to decode.
module fetch_unit_q
   import fetch_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                IMM_W      = 16,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
)(
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [DATA_W-1:0] imem_rsp_data,
   input  logic [3:0]        flags,
   input  logic              flags_valid,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_data,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              br_resolved,
   output logic              br_taken
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   logic [DATA_W-1:0] q_data [FIFO_DEPTH];
   logic [ADDR_W-1:0] q_pc   [FIFO_DEPTH];

   fetch_state_e      state_reg, state_next;
   logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
   logic [ADDR_W-1:0] req_pc_reg, req_pc_next;
   logic              drop_reg, drop_next;
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg, count_next;

   logic [DATA_W-1:0] head_data;
   logic [ADDR_W-1:0] head_pc, br_target, flush_pc;
   logic [IMM_W-1:0]  head_imm;
   logic [3:0]        head_cond;
   logic              q_empty, head_is_br, needs_flags, cond_taken;
   logic              br_fire, br_take, flush, deliver, push, pop, req_fire;

   assign head_data   = q_data[rd_ptr_reg];
   assign head_pc     = q_pc[rd_ptr_reg];
   assign q_empty     = (count_reg == '0);
   assign head_is_br  = !q_empty && (head_data[DATA_W-1 -: 3] == BR_CLASS);
   assign head_cond   = head_data[DATA_W-4 -: 4];
   assign head_imm    = head_data[IMM_W-1:0];
   assign br_target   = head_pc + {{(ADDR_W-IMM_W){head_imm[IMM_W-1]}}, head_imm};
   assign needs_flags = (head_cond != COND_AL) && (head_cond != COND_NV);

   cond_eval u_cond_eval (
      .flags (flags),
      .cond  (head_cond),
      .taken (cond_taken)
   );

   // An external redirect swallows a branch resolving in the same cycle.
   assign br_fire  = head_is_br && (flags_valid || !needs_flags) && !redirect_valid;
   assign br_take  = br_fire && cond_taken;
   assign flush    = redirect_valid || br_take;
   assign flush_pc = redirect_valid ? redirect_pc : br_target;

   assign deliver  = !q_empty && !head_is_br;
   assign pop      = (deliver && instr_ready) || br_fire;
   assign req_fire = (state_reg == ST_REQ) && imem_req_ready;
   assign push     = (state_reg == ST_WAIT) && imem_rsp_valid && !drop_reg && !flush;

   always_comb begin
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
      if (flush) count_next = '0;
   end

   always_comb begin
      state_next    = state_reg;
      fetch_pc_next = fetch_pc_reg;
      req_pc_next   = req_pc_reg;
      drop_next     = drop_reg;
      case (state_reg)
         ST_IDLE: if (count_reg < DEPTH_C) state_next = ST_REQ;
         ST_REQ: begin
            if (req_fire) begin
               req_pc_next   = fetch_pc_reg;
               fetch_pc_next = fetch_pc_reg + ADDR_W'(4);
               state_next    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_rsp_valid) begin
               drop_next  = 1'b0;
               state_next = (count_next < DEPTH_C) ? ST_REQ : ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      // A request accepted now, or a response still owed, belongs to the old path.
      if (flush) begin
         fetch_pc_next = flush_pc;
         if (req_fire || ((state_reg == ST_WAIT) && !imem_rsp_valid)) drop_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         fetch_pc_reg <= RESET_PC;
         req_pc_reg   <= '0;
         drop_reg     <= 1'b0;
         count_reg    <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         fetch_pc_reg <= fetch_pc_next;
         req_pc_reg   <= req_pc_next;
         drop_reg     <= drop_next;
         count_reg    <= count_next;
         if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_data[wr_ptr_reg] <= imem_rsp_data;
         q_pc[wr_ptr_reg]   <= req_pc_reg;
      end
   end

   assign imem_req_valid = (state_reg == ST_REQ);
   assign imem_req_addr  = imem_req_valid ? fetch_pc_reg : '0;
   assign instr_valid    = deliver;
   assign instr_data     = deliver ? head_data : '0;
   assign instr_pc       = deliver ? head_pc : '0;
   assign br_resolved    = br_fire;
   assign br_taken       = br_take;

endmodule

// File: tb/tb_fetch_unit_q.sv
// Directed bench for fetch_unit_q: memory responder with programmable latency,
// logs of requests / deliveries / branch resolutions, hand-computed expectations.
module tb_fetch_unit_q;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic [3:0]  flags = '0;
   logic        flags_valid = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        br_resolved;
   logic        br_taken;

   fetch_unit_q dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .flags          (flags),
      .flags_valid    (flags_valid),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc),
      .br_resolved    (br_resolved),
      .br_taken       (br_taken)
   );

   always #5 clk = ~clk;

   // 0xDC00_FFF8: class 110, cond 1110 (al), imm -8.  0xC000_FFF8: cond 0000 (eq), imm -8.
   localparam logic [31:0] B_AL_M8 = 32'hDC00_FFF8;
   localparam logic [31:0] B_EQ_M8 = 32'hC000_FFF8;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int rsp_lat = 1;
   bit keep_late = 1'b0;

   logic [31:0] prog [logic [31:0]];
   logic [31:0] req_log [$];
   logic [31:0] deliv_pc [$];
   logic [31:0] deliv_data [$];
   int          deliv_cyc [$];
   bit          br_log [$];

   bit          rsp_pend = 1'b0;
   int          rsp_cnt = 0;
   logic [31:0] rsp_addr = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (prog.exists(a)) return prog[a];
      return (a >> 2) + 32'd1;
   endfunction

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("pass %s: 0x%0h", tag, got);
      end
   endtask

   // Monitor and memory model act 2 time units after each falling edge.
   always @(negedge clk) begin
      #2;
      cyc++;
      if (!reset) begin
         req_log.delete();
         deliv_pc.delete();
         deliv_data.delete();
         deliv_cyc.delete();
         br_log.delete();
         if (!keep_late) begin
            rsp_pend = 1'b0;
            imem_rsp_valid = 1'b0;
         end
      end else begin
         if (instr_valid && instr_ready) begin
            deliv_pc.push_back(instr_pc);
            deliv_data.push_back(instr_data);
            deliv_cyc.push_back(cyc);
         end
         if (br_resolved) br_log.push_back(br_taken);
      end
      if (rsp_pend && rsp_cnt == 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(rsp_addr);
         rsp_pend       = 1'b0;
      end else begin
         imem_rsp_valid = 1'b0;
         if (rsp_pend) rsp_cnt--;
      end
      if (reset && imem_req_valid && imem_req_ready && !rsp_pend) begin
         req_log.push_back(imem_req_addr);
         rsp_pend = 1'b1;
         rsp_cnt  = rsp_lat - 1;
         rsp_addr = imem_req_addr;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      instr_ready = 1'b1;
      imem_req_ready = 1'b1;
      flags = '0;
      flags_valid = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_deliv(input int n, input string tag);
      int k = 0;
      while (deliv_pc.size() < n && k < 300) begin
         @(negedge clk);
         k++;
      end
      check_value({tag, "_deliv_count"}, 64'(deliv_pc.size() >= n), 64'd1);
   endtask

   task automatic wait_req(input int n, input string tag);
      int k = 0;
      while (req_log.size() < n && k < 300) begin
         @(negedge clk);
         k++;
      end
      check_value({tag, "_req_count"}, 64'(req_log.size() >= n), 64'd1);
   endtask

   task automatic wait_br(input string tag);
      int k = 0;
      while (br_log.size() < 1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check_value({tag, "_br_seen"}, 64'(br_log.size() >= 1), 64'd1);
   endtask

   initial begin
      int sz;
      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check_value("rst_req_valid", imem_req_valid, 0);
      check_value("rst_req_addr", imem_req_addr, 0);
      check_value("rst_instr_valid", instr_valid, 0);
      check_value("rst_instr_data", instr_data, 0);
      check_value("rst_br_resolved", br_resolved, 0);

      // Straight line
      prog.delete();
      rsp_lat = 1;
      do_reset();
      wait_deliv(4, "line");
      for (int i = 0; i < 4; i++) begin
         check_value($sformatf("line_req%0d", i), req_log[i], 32'(4 * i));
         check_value($sformatf("line_pc%0d", i), deliv_pc[i], 32'(4 * i));
         check_value($sformatf("line_data%0d", i), deliv_data[i], 32'(i + 1));
      end

      // Backpressure: queue fills to FIFO_DEPTH, then drains one per cycle
      do_reset();
      instr_ready = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      check_value("bp_req_count", req_log.size(), 4);
      check_value("bp_req_valid_low", imem_req_valid, 0);
      check_value("bp_head_valid", instr_valid, 1);
      check_value("bp_head_pc", instr_pc, 0);
      instr_ready = 1'b1;
      wait_deliv(6, "bp");
      for (int i = 0; i < 6; i++) begin
         check_value($sformatf("bp_pc%0d", i), deliv_pc[i], 32'(4 * i));
         check_value($sformatf("bp_data%0d", i), deliv_data[i], 32'(i + 1));
      end
      check_value("bp_burst_span", deliv_cyc[3] - deliv_cyc[0], 3);

      // Unconditional backward branch at 0x10 -> 0x08
      prog.delete();
      prog[32'h10] = B_AL_M8;
      do_reset();
      wait_deliv(6, "bal");
      wait_br("bal");
      check_value("bal_taken", br_log[0], 1);
      check_value("bal_req5", req_log[5], 32'h14);
      check_value("bal_req6", req_log[6], 32'h08);
      check_value("bal_pc4", deliv_pc[4], 32'h08);
      check_value("bal_data4", deliv_data[4], 32'd3);
      check_value("bal_pc5", deliv_pc[5], 32'h0C);

      // Conditional beq waits on flags_valid, then taken with Z=1
      prog.delete();
      prog[32'h10] = B_EQ_M8;
      do_reset();
      flags_valid = 1'b0;
      wait_deliv(4, "beq_t");
      repeat (10) @(negedge clk);
      #1;
      check_value("beq_t_held_deliv", deliv_pc.size(), 4);
      check_value("beq_t_held_br", br_log.size(), 0);
      check_value("beq_t_head_blocked", instr_valid, 0);
      flags = 4'b0010;
      flags_valid = 1'b1;
      wait_br("beq_t");
      check_value("beq_t_taken", br_log[0], 1);
      wait_deliv(5, "beq_t");
      check_value("beq_t_pc4", deliv_pc[4], 32'h08);

      // Same beq with flags=0: not taken, sequential fetch continues
      do_reset();
      flags_valid = 1'b0;
      wait_deliv(4, "beq_n");
      repeat (5) @(negedge clk);
      flags = 4'b0000;
      flags_valid = 1'b1;
      wait_br("beq_n");
      check_value("beq_n_taken", br_log[0], 0);
      wait_deliv(6, "beq_n");
      check_value("beq_n_pc4", deliv_pc[4], 32'h14);
      check_value("beq_n_data4", deliv_data[4], 32'd6);
      check_value("beq_n_pc5", deliv_pc[5], 32'h18);

      // Redirect collides with a taken branch: redirect wins, no resolution
      do_reset();
      flags_valid = 1'b0;
      wait_deliv(4, "col");
      repeat (20) @(negedge clk);
      flags = 4'b0010;
      flags_valid = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      #1;
      check_value("col_br_resolved", br_resolved, 0);
      sz = req_log.size();
      @(negedge clk);
      redirect_valid = 1'b0;
      flags_valid = 1'b0;
      wait_req(sz + 1, "col");
      check_value("col_req_addr", req_log[sz], 32'h100);
      wait_deliv(5, "col");
      check_value("col_pc4", deliv_pc[4], 32'h100);
      check_value("col_data4", deliv_data[4], 32'h41);
      check_value("col_no_br", br_log.size(), 0);

      // Async reset mid-WAIT; the late response must be ignored
      prog.delete();
      rsp_lat = 3;
      do_reset();
      keep_late = 1'b1;
      wait_req(2, "ar");
      reset = 1'b0;
      #1;
      check_value("ar_req_valid", imem_req_valid, 0);
      check_value("ar_req_addr", imem_req_addr, 0);
      check_value("ar_instr_valid", instr_valid, 0);
      check_value("ar_br_resolved", br_resolved, 0);
      @(negedge clk);
      reset = 1'b1;
      wait_deliv(2, "ar");
      check_value("ar_first_req", req_log[0], 32'h0);
      check_value("ar_pc0", deliv_pc[0], 32'h0);
      check_value("ar_data0", deliv_data[0], 32'd1);
      check_value("ar_pc1", deliv_pc[1], 32'h4);
      check_value("ar_data1", deliv_data[1], 32'd2);
      keep_late = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
